// File: rtl/sonar_ping_sequencer.sv
// sonar_ping_sequencer: one sonar ping per cycle of tx burst, ring-down blanking, ping-pong RAM capture and frame-aligned bank swap
// Ports: clk/nRST system clock and async active-low reset; enable keeps pinging;
//   sample_clk_in ADC strobe (clk domain); vsync_in LCD frame sync (async);
//   tx_p/tx_n complementary transducer drive; wr_en/wr_addr/wr_bank RAM write port;
//   rd_bank display bank; capturing, swap_pulse status; ping_count completed pings.
module sonar_ping_sequencer #(
  parameter int HALF_PERIOD   = 338,
  parameter int TX_CYCLES     = 8,
  parameter int BLANK_SAMPLES = 64,
  parameter int DEPTH         = 2048,
  parameter int ADDR_W        = 11
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              enable,
  input  logic              sample_clk_in,
  input  logic              vsync_in,
  output logic              tx_p,
  output logic              tx_n,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              capturing,
  output logic              swap_pulse,
  output logic [15:0]       ping_count
);
  localparam int PW = $clog2(HALF_PERIOD + 1);
  localparam int HW = $clog2(2 * TX_CYCLES + 1);
  localparam int BW = $clog2(BLANK_SAMPLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_BURST, S_BLANK, S_CAPTURE, S_WAIT} state_t;
  state_t r_state, w_next;
  logic r_smp_d, r_tx_p, r_tx_n, r_wr_en, r_rd_bank, r_swap;
  logic [2:0] r_vs;
  logic [PW-1:0] r_phase;
  logic [HW-1:0] r_half;
  logic [BW-1:0] r_blank;
  logic [ADDR_W-1:0] r_addr, r_wr_addr;
  logic [15:0] r_ping;
  logic w_smp_edge, w_vs_edge, w_half_done, w_burst_done, w_blank_done, w_cap_done, w_swap;
  assign w_smp_edge   = sample_clk_in & ~r_smp_d;
  assign w_vs_edge    = r_vs[1] & ~r_vs[2];
  assign w_half_done  = r_phase == PW'(HALF_PERIOD - 1);
  assign w_burst_done = w_half_done && r_half == HW'(2 * TX_CYCLES - 1);
  assign w_blank_done = w_smp_edge && r_blank == BW'(BLANK_SAMPLES - 1);
  assign w_cap_done   = w_smp_edge && r_addr == ADDR_W'(DEPTH - 1);
  // a frame edge landing on the final write pulse is dropped so the bank never flips under a write
  assign w_swap       = r_state == S_WAIT && w_vs_edge && !r_wr_en;
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = enable ? S_BURST : S_IDLE;
      S_BURST:   w_next = w_burst_done ? S_BLANK : S_BURST;
      S_BLANK:   w_next = w_blank_done ? S_CAPTURE : S_BLANK;
      S_CAPTURE: w_next = w_cap_done ? S_WAIT : S_CAPTURE;
      S_WAIT:    w_next = w_swap ? (enable ? S_BURST : S_IDLE) : S_WAIT;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_smp_d   <= 1'b0;
      r_vs      <= '0;
      r_tx_p    <= 1'b0;
      r_tx_n    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_bank <= 1'b0;
      r_swap    <= 1'b0;
      r_phase   <= '0;
      r_half    <= '0;
      r_blank   <= '0;
      r_addr    <= '0;
      r_wr_addr <= '0;
      r_ping    <= '0;
    end else begin
      r_smp_d <= sample_clk_in;
      r_vs    <= {r_vs[1:0], vsync_in};
      r_wr_en <= r_state == S_CAPTURE && w_smp_edge;
      r_swap  <= w_swap;
      if (w_swap) begin
        r_rd_bank <= ~r_rd_bank;
        r_ping    <= r_ping + 16'd1;
      end
      if (r_state != S_BURST && w_next == S_BURST) begin
        r_phase <= '0;
        r_half  <= '0;
        r_tx_p  <= 1'b1;
        r_tx_n  <= 1'b0;
      end else if (r_state == S_BURST) begin
        r_phase <= w_half_done ? '0 : r_phase + 1'b1;
        if (w_half_done) begin
          r_half <= r_half + 1'b1;
          r_tx_p <= ~w_burst_done & ~r_tx_p;
          r_tx_n <= ~w_burst_done & r_tx_p;
        end
      end
      if (r_state == S_BURST) r_blank <= '0;
      else if (r_state == S_BLANK && w_smp_edge) r_blank <= r_blank + 1'b1;
      if (r_state == S_BLANK) r_addr <= '0;
      else if (r_state == S_CAPTURE && w_smp_edge) begin
        r_wr_addr <= r_addr;
        r_addr    <= w_cap_done ? '0 : r_addr + 1'b1;
      end
    end
  end
  assign tx_p       = r_tx_p;
  assign tx_n       = r_tx_n;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign rd_bank    = r_rd_bank;
  assign wr_bank    = ~r_rd_bank;
  assign capturing  = r_state == S_CAPTURE;
  assign swap_pulse = r_swap;
  assign ping_count = r_ping;
endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// tb_sonar_ping_sequencer: directed checks of burst timing, blanking, capture, bank swap and stop
module tb_sonar_ping_sequencer;
  logic clk = 1'b0, nRST = 1'b0, enable = 1'b0, sample_clk_in = 1'b0, vsync_in = 1'b0;
  logic tx_p, tx_n, wr_en, wr_bank, rd_bank, capturing, swap_pulse;
  logic [10:0] wr_addr;
  logic [15:0] ping_count;
  int total = 0, bad = 0, n_wr = 0, n_swap = 0, lat_bad = 0, n0 = 0, k = 0, idle_bad = 0;
  typedef struct {int k; logic p; logic n;} vec_t;
  vec_t tab[11];
  sonar_ping_sequencer dut (
    .clk(clk), .nRST(nRST), .enable(enable), .sample_clk_in(sample_clk_in), .vsync_in(vsync_in),
    .tx_p(tx_p), .tx_n(tx_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .capturing(capturing), .swap_pulse(swap_pulse), .ping_count(ping_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (nRST) begin
    n_wr   += int'(wr_en);
    n_swap += int'(swap_pulse);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic strobe(input int addr, input bit expect_wr);
    sample_clk_in = 1'b1;
    tick();
    if (expect_wr && !(wr_en && int'(wr_addr) == addr)) lat_bad++;
    if (!expect_wr && wr_en) lat_bad++;
    tick();
    if (wr_en) lat_bad++;
    sample_clk_in = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    tab = '{'{0, 0, 0}, '{1, 1, 0}, '{338, 1, 0}, '{339, 0, 1}, '{676, 0, 1}, '{677, 1, 0},
            '{2000, 0, 1}, '{5070, 1, 0}, '{5071, 0, 1}, '{5408, 0, 1}, '{5409, 0, 0}};
    repeat (3) tick();
    chk("rst_tx_p", tx_p, 0);
    chk("rst_tx_n", tx_n, 0);
    chk("rst_wr_bank", wr_bank, 1);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_ping", ping_count, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_cap", capturing, 0);
    nRST = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) strobe(0, 0);
    vsync_in = 1'b1;
    repeat (5) tick();
    vsync_in = 1'b0;
    repeat (5) tick();
    chk("idle_no_wr", n_wr, 0);
    chk("idle_no_swap", n_swap, 0);
    chk("idle_lat", lat_bad, 0);
    enable = 1'b1;
    k = 0;
    for (int i = 0; i < 11; i++) begin
      while (k < tab[i].k) begin
        tick();
        k++;
        vsync_in = k >= 1000 && k < 1010;
        sample_clk_in = k >= 2000 && k < 2003;
      end
      chk($sformatf("burst_p k=%0d", k), tx_p, tab[i].p);
      chk($sformatf("burst_n k=%0d", k), tx_n, tab[i].n);
      chk($sformatf("burst_cap k=%0d", k), capturing, 0);
    end
    for (int i = 0; i < 64; i++) strobe(0, 0);
    chk("blank_no_wr", n_wr, 0);
    chk("burst_vsync_ignored", n_swap, 0);
    chk("blank_to_capture", capturing, 1);
    n0 = n_wr;
    for (int i = 0; i < 2048; i++) begin
      if (i == 100) vsync_in = 1'b1;
      if (i == 103) vsync_in = 1'b0;
      strobe(i, 1);
    end
    chk("cap_pulses", n_wr - n0, 2048);
    chk("cap_addr_latency", lat_bad, 0);
    chk("cap_done", capturing, 0);
    chk("cap_vsync_ignored", n_swap, 0);
    repeat (1000) tick();
    chk("wait_rd_bank", rd_bank, 0);
    chk("wait_no_swap", n_swap, 0);
    vsync_in = 1'b1;
    tick();
    tick();
    chk("swap_early", swap_pulse, 0);
    tick();
    chk("swap_pulse", swap_pulse, 1);
    chk("swap_rd_bank", rd_bank, 1);
    chk("swap_wr_bank", wr_bank, 0);
    chk("swap_ping", ping_count, 1);
    chk("swap_reburst", tx_p, 1);
    tick();
    chk("swap_one_cycle", swap_pulse, 0);
    vsync_in = 1'b0;
    repeat (5406) tick();
    chk("p2_last_half_n", tx_n, 1);
    tick();
    chk("p2_burst_end_p", tx_p, 0);
    chk("p2_burst_end_n", tx_n, 0);
    for (int i = 0; i < 64; i++) strobe(0, 0);
    n0 = n_wr;
    for (int i = 0; i < 2047; i++) begin
      if (i == 500) enable = 1'b0;
      strobe(i, 1);
    end
    vsync_in = 1'b1;
    tick();
    strobe(2047, 1);
    chk("p2_pulses", n_wr - n0, 2048);
    chk("p2_addr_latency", lat_bad, 0);
    repeat (50) tick();
    chk("last_write_vsync_ignored", n_swap, 1);
    chk("last_write_rd_bank", rd_bank, 1);
    vsync_in = 1'b0;
    repeat (3) tick();
    vsync_in = 1'b1;
    repeat (3) tick();
    chk("stop_swap", swap_pulse, 1);
    chk("stop_rd_bank", rd_bank, 0);
    chk("stop_wr_bank", wr_bank, 1);
    chk("stop_ping", ping_count, 2);
    vsync_in = 1'b0;
    n0 = n_wr;
    for (int i = 0; i < 1000; i++) begin
      sample_clk_in = i % 4 < 2;
      tick();
      if (tx_p || tx_n || capturing) idle_bad++;
    end
    sample_clk_in = 1'b0;
    chk("stop_idle", idle_bad, 0);
    chk("stop_no_wr", n_wr - n0, 0);
    enable = 1'b1;
    repeat (100) tick();
    chk("rst2_burst_on", tx_p, 1);
    #2 nRST = 1'b0;
    #1;
    chk("rst2_tx_p", tx_p, 0);
    chk("rst2_tx_n", tx_n, 0);
    chk("rst2_wr_bank", wr_bank, 1);
    chk("rst2_rd_bank", rd_bank, 0);
    chk("rst2_ping", ping_count, 0);
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
